// File: rtl/shared_math_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_math_arbiter_pkg
// Description : Shared constants for the math-resource arbiter: FSM state
//               encodings, shared bus widths and the default watchdog limit.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package shared_math_arbiter_pkg;

   // Arbiter FSM encodings
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   // Shared bus widths
   localparam int ADD_W   = 16;
   localparam int LADD_W  = 32;
   localparam int MADDR_W = 12;
   localparam int MDATA_W = 32;

   // Default grant-hold limit before the watchdog flags an error
   localparam logic [15:0] DEFAULT_MAX_HOLD = 16'd4000;

endpackage
`default_nettype wire

// File: rtl/shared_math_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : shared_math_arbiter_rr_priority_pick
// Description : Combinational round-robin pick. Returns the first set request
//               bit searching upward from rr_ptr, wrapping around to bit 0.
// Ports       : req        - request vector
//               rr_ptr     - index where the search starts
//               winner     - one-hot winner (zero when req is zero)
//               winner_idx - index of the winner (zero when req is zero)
// Revision    : 1.0  initial release
// ============================================================================
module shared_math_arbiter_rr_priority_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [NREQ-1:0] winner,
   output logic [IDW-1:0]  winner_idx
);

   logic [NREQ-1:0] upper_mask;
   logic [NREQ-1:0] upper_req;
   logic [NREQ-1:0] pick_src;

   // Requests at or above rr_ptr take precedence; if none exist the search
   // wraps, which is simply the lowest set bit of the full request vector.
   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (i >= int'(rr_ptr)) upper_mask[i] = 1'b1;
      end
      upper_req = req & upper_mask;
      pick_src  = (upper_req != '0) ? upper_req : req;

      // Scan downward so the lowest set bit is the last one written
      winner     = '0;
      winner_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (pick_src[i]) begin
            winner     = '0;
            winner[i]  = 1'b1;
            winner_idx = IDW'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/shared_math_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_math_arbiter
// Description : Round-robin arbiter sharing the add / L_add operand buses and
//               the scratch-memory port among NREQ sub-FSMs. Grant is locked
//               to a requester until it drops req; a sticky watchdog flags
//               grants held for MAX_HOLD cycles.
// Ports       : clk, reset (sync, active-high)
//               req, *_bus        - per-requester request and bus slices
//               gnt, busy, owner  - registered grant status
//               addOut*, L_addOut*, mem* - shared outputs of the owner
//               hold_err          - sticky watchdog flag
// Revision    : 1.0  initial release
// ============================================================================
module shared_math_arbiter
   import shared_math_arbiter_pkg::*;
#(
   parameter int          NREQ     = 4,
   parameter int          IDW      = 3,
   parameter logic [15:0] MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [ADD_W*NREQ-1:0]   addA_bus,
   input  logic [ADD_W*NREQ-1:0]   addB_bus,
   input  logic [LADD_W*NREQ-1:0]  L_addA_bus,
   input  logic [LADD_W*NREQ-1:0]  L_addB_bus,
   input  logic [MADDR_W*NREQ-1:0] rdAddr_bus,
   input  logic [MADDR_W*NREQ-1:0] wrAddr_bus,
   input  logic [MDATA_W*NREQ-1:0] wrData_bus,
   input  logic [NREQ-1:0]         wrEn_bus,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic [IDW-1:0]          owner,
   output logic [ADD_W-1:0]        addOutA,
   output logic [ADD_W-1:0]        addOutB,
   output logic [LADD_W-1:0]       L_addOutA,
   output logic [LADD_W-1:0]       L_addOutB,
   output logic [MADDR_W-1:0]      memReadAddr,
   output logic [MADDR_W-1:0]      memWriteAddr,
   output logic [MDATA_W-1:0]      memOut,
   output logic                    memWriteEn,
   output logic                    hold_err
);

   logic [0:0]      state, state_next;
   logic [NREQ-1:0] gnt_next;
   logic            busy_next;
   logic [IDW-1:0]  owner_next;
   logic [IDW-1:0]  rr_ptr, rr_ptr_next;
   logic [15:0]     hold_cnt, hold_cnt_next;
   logic            hold_err_next;

   logic [NREQ-1:0] pick_onehot;
   logic [IDW-1:0]  pick_idx;
   logic            owner_req;

   shared_math_arbiter_rr_priority_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req        (req),
      .rr_ptr     (rr_ptr),
      .winner     (pick_onehot),
      .winner_idx (pick_idx)
   );

   // gnt is one-hot while busy, so this is req[owner] without a wide index
   assign owner_req = |(req & gnt);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         gnt      <= '0;
         busy     <= 1'b0;
         owner    <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         hold_err <= 1'b0;
      end else begin
         state    <= state_next;
         gnt      <= gnt_next;
         busy     <= busy_next;
         owner    <= owner_next;
         rr_ptr   <= rr_ptr_next;
         hold_cnt <= hold_cnt_next;
         hold_err <= hold_err_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next    = state;
      gnt_next      = gnt;
      busy_next     = busy;
      owner_next    = owner;
      rr_ptr_next   = rr_ptr;
      hold_cnt_next = hold_cnt;
      hold_err_next = hold_err;

      case (state)
         IDLE: begin
            if (req != '0) begin
               state_next    = GRANT;
               gnt_next      = pick_onehot;
               busy_next     = 1'b1;
               owner_next    = pick_idx;
               hold_cnt_next = '0;
            end
         end
         GRANT: begin
            if (hold_cnt != 16'hFFFF) hold_cnt_next = hold_cnt + 16'd1;
            if (owner_req) begin
               // Flag only; the grant is never revoked by the watchdog
               if (hold_cnt == MAX_HOLD - 16'd1) hold_err_next = 1'b1;
            end else begin
               state_next = IDLE;
               gnt_next   = '0;
               busy_next  = 1'b0;
               // Next search starts just past the releasing owner
               if (int'(owner) >= NREQ - 1) rr_ptr_next = '0;
               else                         rr_ptr_next = owner + IDW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = '0;
            busy_next  = 1'b0;
         end
      endcase
   end

   // Output mux: AND-OR over the registered one-hot grant, so every
   // non-owner slice is masked and all outputs are zero while gnt is zero.
   always_comb begin
      addOutA      = '0;
      addOutB      = '0;
      L_addOutA    = '0;
      L_addOutB    = '0;
      memReadAddr  = '0;
      memWriteAddr = '0;
      memOut       = '0;
      memWriteEn   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            addOutA      = addA_bus[i*ADD_W +: ADD_W];
            addOutB      = addB_bus[i*ADD_W +: ADD_W];
            L_addOutA    = L_addA_bus[i*LADD_W +: LADD_W];
            L_addOutB    = L_addB_bus[i*LADD_W +: LADD_W];
            memReadAddr  = rdAddr_bus[i*MADDR_W +: MADDR_W];
            memWriteAddr = wrAddr_bus[i*MADDR_W +: MADDR_W];
            memOut       = wrData_bus[i*MDATA_W +: MDATA_W];
            memWriteEn   = wrEn_bus[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shared_math_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_math_arbiter
// Description : Self-checking bench for shared_math_arbiter. A cycle-level
//               model of the arbitration rules predicts every output; literal
//               checks pin the model at the key points of each scenario.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shared_math_arbiter;

   localparam int          NREQ = 4;
   localparam int          IDW  = 3;
   localparam logic [15:0] MAXH = 16'd10;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [16*NREQ-1:0] addA_bus, addB_bus;
   logic [32*NREQ-1:0] L_addA_bus, L_addB_bus;
   logic [12*NREQ-1:0] rdAddr_bus, wrAddr_bus;
   logic [32*NREQ-1:0] wrData_bus;
   logic [NREQ-1:0]    wrEn_bus = '0;

   logic [NREQ-1:0] gnt;
   logic            busy;
   logic [IDW-1:0]  owner;
   logic [15:0]     addOutA, addOutB;
   logic [31:0]     L_addOutA, L_addOutB;
   logic [11:0]     memReadAddr, memWriteAddr;
   logic [31:0]     memOut;
   logic            memWriteEn;
   logic            hold_err;

   int vectors     = 0;
   int miscompares = 0;
   logic started   = 1'b0;

   always #5 clk = ~clk;

   shared_math_arbiter #(
      .NREQ     (NREQ),
      .IDW      (IDW),
      .MAX_HOLD (MAXH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .addA_bus     (addA_bus),
      .addB_bus     (addB_bus),
      .L_addA_bus   (L_addA_bus),
      .L_addB_bus   (L_addB_bus),
      .rdAddr_bus   (rdAddr_bus),
      .wrAddr_bus   (wrAddr_bus),
      .wrData_bus   (wrData_bus),
      .wrEn_bus     (wrEn_bus),
      .gnt          (gnt),
      .busy         (busy),
      .owner        (owner),
      .addOutA      (addOutA),
      .addOutB      (addOutB),
      .L_addOutA    (L_addOutA),
      .L_addOutB    (L_addOutB),
      .memReadAddr  (memReadAddr),
      .memWriteAddr (memWriteAddr),
      .memOut       (memOut),
      .memWriteEn   (memWriteEn),
      .hold_err     (hold_err)
   );

   // ---------------- behavioural model ----------------
   logic m_busy = 1'b0;
   int   m_owner = 0;
   int   m_ptr = 0;
   int   m_cnt = 0;
   logic m_err = 1'b0;

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int d = 0; d < NREQ; d++) begin
         if (r[(p + d) % NREQ]) return (p + d) % NREQ;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_owner <= 0;
         m_ptr   <= 0;
         m_cnt   <= 0;
         m_err   <= 1'b0;
      end else if (!m_busy) begin
         if (req != '0) begin
            m_busy  <= 1'b1;
            m_owner <= rr_pick(req, m_ptr);
            m_cnt   <= 0;
         end
      end else if (req[m_owner]) begin
         if (m_cnt == int'(MAXH) - 1) m_err <= 1'b1;
         if (m_cnt < 65535) m_cnt <= m_cnt + 1;
      end else begin
         m_busy <= 1'b0;
         m_ptr  <= (m_owner + 1) % NREQ;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         logic [NREQ-1:0] eg;
         vectors++;
         eg = m_busy ? (NREQ'(1) << m_owner) : '0;
         chk("gnt",          32'(gnt),          32'(eg));
         chk("busy",         32'(busy),         32'(m_busy));
         chk("owner",        32'(owner),        32'(m_owner));
         chk("hold_err",     32'(hold_err),     32'(m_err));
         chk("addOutA",      32'(addOutA),      m_busy ? 32'(addA_bus[m_owner*16 +: 16]) : 32'd0);
         chk("addOutB",      32'(addOutB),      m_busy ? 32'(addB_bus[m_owner*16 +: 16]) : 32'd0);
         chk("L_addOutA",    L_addOutA,         m_busy ? L_addA_bus[m_owner*32 +: 32] : 32'd0);
         chk("L_addOutB",    L_addOutB,         m_busy ? L_addB_bus[m_owner*32 +: 32] : 32'd0);
         chk("memReadAddr",  32'(memReadAddr),  m_busy ? 32'(rdAddr_bus[m_owner*12 +: 12]) : 32'd0);
         chk("memWriteAddr", 32'(memWriteAddr), m_busy ? 32'(wrAddr_bus[m_owner*12 +: 12]) : 32'd0);
         chk("memOut",       memOut,            m_busy ? wrData_bus[m_owner*32 +: 32] : 32'd0);
         chk("memWriteEn",   32'(memWriteEn),   32'(m_busy & wrEn_bus[m_owner]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      chk(name, act, exp);
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         addA_bus[i*16 +: 16]   = 16'h1000 + 16'(i * 16'h0111);
         addB_bus[i*16 +: 16]   = 16'h2000 + 16'(i * 16'h0111);
         L_addA_bus[i*32 +: 32] = 32'hA000_0000 + 32'(i);
         L_addB_bus[i*32 +: 32] = 32'hB000_0000 + 32'(i);
         rdAddr_bus[i*12 +: 12] = 12'h300 + 12'(i);
         wrAddr_bus[i*12 +: 12] = 12'h400 + 12'(i);
         wrData_bus[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      end
      addA_bus[2*16 +: 16]  = 16'h1234;
      wrAddr_bus[0*12 +: 12] = 12'h123;
      wrAddr_bus[1*12 +: 12] = 12'h0A5;

      // Reset
      reset = 1'b1;
      step(1);
      started = 1'b1;
      step(1);
      @(negedge clk);
      lit("rst_gnt", 32'(gnt), 32'd0);
      lit("rst_busy", 32'(busy), 32'd0);
      lit("rst_addOutA", 32'(addOutA), 32'd0);
      reset = 1'b0;

      // Single requester
      req = 4'b0100;
      step(1);
      @(negedge clk);
      lit("single_gnt", 32'(gnt), 32'h4);
      lit("single_owner", 32'(owner), 32'd2);
      lit("single_addOutA", 32'(addOutA), 32'h1234);
      step(4);
      req = 4'b0000;
      step(1);
      @(negedge clk);
      lit("single_rel_gnt", 32'(gnt), 32'd0);
      lit("single_rel_addOutA", 32'(addOutA), 32'd0);

      // Round-robin fairness from a fresh pointer
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      req = 4'b1111;
      step(1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         lit("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
         lit("rr_owner", 32'(owner), 32'(k % 4));
         step(2);
         req[k % 4] = 1'b0;
         step(1);
         req = (k == 4) ? 4'b0000 : 4'b1111;
         @(negedge clk);
         lit("rr_idle_gnt", 32'(gnt), 32'd0);
         step(1);
      end

      // Write masking (pointer is 1 here, requester 0 wins by wrap)
      req = 4'b0001;
      wrEn_bus = 4'b0010;
      step(1);
      @(negedge clk);
      lit("wm_gnt", 32'(gnt), 32'h1);
      lit("wm_wen_masked", 32'(memWriteEn), 32'd0);
      lit("wm_waddr", 32'(memWriteAddr), 32'h123);
      step(1);
      wrEn_bus = 4'b0011;
      @(negedge clk);
      lit("wm_wen_owner", 32'(memWriteEn), 32'd1);
      req = 4'b0000;
      step(1);
      @(negedge clk);
      lit("wm_release_wen", 32'(memWriteEn), 32'd0);
      wrEn_bus = 4'b0000;

      // Simultaneous drop/raise: owner 3 drops as requester 0 rises
      req = 4'b1000;
      step(1);
      @(negedge clk);
      lit("sim_gnt3", 32'(gnt), 32'h8);
      step(1);
      req = 4'b0001;
      step(1);
      @(negedge clk);
      lit("sim_idle_gnt", 32'(gnt), 32'd0);
      step(1);
      @(negedge clk);
      lit("sim_gnt0", 32'(gnt), 32'h1);
      req = 4'b0000;
      step(1);

      // Watchdog: requester 0 holds for 12 grant cycles
      req = 4'b0001;
      step(1);
      step(9);
      @(negedge clk);
      lit("wd_err_cycle10", 32'(hold_err), 32'd0);
      lit("wd_gnt_cycle10", 32'(gnt), 32'h1);
      step(1);
      @(negedge clk);
      lit("wd_err_cycle11", 32'(hold_err), 32'd1);
      lit("wd_gnt_cycle11", 32'(gnt), 32'h1);
      step(1);
      req = 4'b0000;
      step(1);
      @(negedge clk);
      lit("wd_err_sticky", 32'(hold_err), 32'd1);
      lit("wd_rel_gnt", 32'(gnt), 32'd0);

      // Reset mid-grant (pointer is 1 before reset)
      req = 4'b0010;
      step(1);
      @(negedge clk);
      lit("rm_gnt", 32'(gnt), 32'h2);
      reset = 1'b1;
      step(1);
      @(negedge clk);
      lit("rm_gnt_clr", 32'(gnt), 32'd0);
      lit("rm_busy_clr", 32'(busy), 32'd0);
      lit("rm_owner_clr", 32'(owner), 32'd0);
      lit("rm_addOutB_clr", 32'(addOutB), 32'd0);
      lit("rm_err_clr", 32'(hold_err), 32'd0);
      reset = 1'b0;
      req = 4'b0011;
      step(1);
      @(negedge clk);
      lit("rm_first_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      step(3);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shared_math_arbiter.md
Name: shared_math_arbiter

Overview:
- Round-robin arbiter that shares one set of arithmetic operand buses (add, L_add) and the single scratch-memory port among up to NREQ sub-FSMs, for example the expand, compose, update and stability engines.
- Each requester holds req for the whole of its operation. Grant is locked to it until req drops.
- The granted requester's operand, address and write buses drive the shared outputs. Every other requester is masked to zero.
- Shared results (addIn, L_addIn, memIn) are broadcast to all requesters outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 3, width of the owner index; must satisfy 2**IDW >= NREQ.
- MAX_HOLD, 16'd4000, grant-hold cycle limit before the watchdog error.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high. Clock: clk.
- req  in  NREQ  per-requester request, level, held until the requester's done.
- addA_bus  in  16*NREQ  add operand A; slice i belongs to requester i.
- addB_bus  in  16*NREQ  add operand B.
- L_addA_bus  in  32*NREQ  L_add operand A.
- L_addB_bus  in  32*NREQ  L_add operand B.
- rdAddr_bus  in  12*NREQ  memory read address.
- wrAddr_bus  in  12*NREQ  memory write address.
- wrData_bus  in  32*NREQ  memory write data.
- wrEn_bus  in  NREQ  memory write enable.
- gnt  out  NREQ  registered one-hot grant.
- busy  out  1  registered; high while in GRANT.
- owner  out  IDW  registered index of the current or last owner.
- addOutA, addOutB  out  16  to the shared add unit.
- L_addOutA, L_addOutB  out  32  to the shared L_add unit.
- memReadAddr  out  12  shared memory read address.
- memWriteAddr  out  12  shared memory write address.
- memOut  out  32  shared memory write data.
- memWriteEn  out  1  shared memory write enable.
- hold_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values:
  - gnt=0, busy=0, owner=0, rr_ptr=0, hold_cnt=0, hold_err=0, state=IDLE.
  - All shared outputs are 0, because they are masked by gnt=0.
- State machine (2 states):
  - IDLE:
    - If req==0, stay in IDLE.
    - Otherwise pick the first set req bit searching from rr_ptr upward, with wrap-around.
    - Register gnt[k]=1, owner=k, busy=1, hold_cnt=0, then go to GRANT.
  - GRANT:
    - If req[owner]==1, stay. Other reqs are ignored, with no preemption.
    - If req[owner]==0, clear gnt and busy, set rr_ptr=(owner+1) mod NREQ, go to IDLE.
- Latency:
  - Grant appears 1 cycle after req is sampled in IDLE.
  - Release takes 1 cycle.
  - So there is a minimum of 1 dead cycle in IDLE between owners, and back-to-back ownership changes take 2 cycles.
- Output mux:
  - Combinational from the registered gnt: out = slice[owner] when busy, else 0.
  - memWriteEn = busy & wrEn_bus[owner]. A write can never issue in IDLE or in the release cycle.
- Simultaneous events:
  - Owner drops req in the same cycle another req rises: release first, then arbitrate in IDLE on the next edge.
  - Several reqs in IDLE: lowest index at or above rr_ptr wins, with wrap.
- Re-request: an owner that drops req and re-raises it immediately competes normally. rr_ptr has already moved past it, so it loses to any other pending requester.
- Watchdog:
  - hold_cnt increments each GRANT cycle and saturates at 16'hFFFF.
  - When hold_cnt==MAX_HOLD-1 and req[owner] is still high, hold_err is set. It stays set until reset.
  - The grant is not revoked.
- Reset mid-operation: on the next edge all registers return to their reset values, and the outputs go to 0 the same cycle the registers clear.
- Out-of-range req bits at or above NREQ do not exist; the width is exactly NREQ.

Decomposition:
- Shared package/include holds:
  - the state encodings (IDLE=1'b0, GRANT=1'b1);
  - the widths ADD_W=16, LADD_W=32, MADDR_W=12, MDATA_W=32;
  - the default MAX_HOLD.
- One natural sub-module, rr_priority_pick: combinational. Inputs are req and rr_ptr; outputs are the one-hot winner plus its index.
- The bus slice mux stays inline.

Test Plan:
- Single requester: req=4'b0100 at cycle 0 -> gnt=4'b0100, owner=2, busy=1 at cycle 1. addA_bus slice2=16'h1234 appears on addOutA. Drop req at cycle 5 -> gnt=0 at cycle 6 and addOutA=0.
- Round-robin fairness: req=4'b1111 held continuously, each owner releasing after 3 cycles -> grant order 0,1,2,3,0, with exactly 1 IDLE cycle between grants.
- Write masking: requester 1 (not granted) drives wrEn=1, wrAddr=12'h0A5 while requester 0 owns -> memWriteEn=0 and memWriteAddr equals requester 0's slice. In the release cycle memWriteEn=0 even if wrEn_bus[0]=1.
- Simultaneous drop/raise: owner 3 drops while req[0] rises in the same cycle -> IDLE for 1 cycle, then gnt=4'b0001 (wrap from rr_ptr=0).
- Watchdog: MAX_HOLD=10, owner holds req for 12 cycles -> hold_err rises after the 10th GRANT cycle, gnt stays high, hold_err stays 1 after release until reset.
- Reset mid-grant: assert reset while gnt=4'b0010 -> next edge gnt=0, busy=0, rr_ptr=0, all shared outputs 0. With req=4'b0011 after reset, requester 0 is granted first.
